// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and grant owner.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port RAM.
// Each access takes IDLE -> ISSUE -> DONE; the ack pulses in DONE.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin contention handling;
// otherwise the data port always wins contention.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_t state;
  gnt_t   grant;
  gnt_t   win;

`ifdef ARB_ROUND_ROBIN_EN
  gnt_t   last_gnt;
`endif

  // RAM read data is presented to both ports; only the acked port consumes it.
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

  // Select the winning requester from the current requests.
  always_comb begin
    win = GNT_IF;
`ifdef ARB_ROUND_ROBIN_EN
    if (if_req && d_req) begin
      win = (last_gnt == GNT_IF) ? GNT_D : GNT_IF;
    end else if (d_req) begin
      win = GNT_D;
    end
`else
    if (d_req) begin
      win = GNT_D;
    end
`endif
  end

  // Access sequencer with registered RAM controls, acks and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= GNT_IF;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt  <= GNT_D;
`endif
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            grant  <= win;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt <= win;
`endif
            if (win == GNT_D) begin
              mem_addr <= d_addr;
              mem_we   <= d_we;
              if (d_we) begin
                mem_wdata <= d_wdata;
              end
            end else begin
              mem_addr <= if_addr;
            end
          end
        end
        ISSUE: begin
          state  <= DONE;
          if_ack <= (grant == GNT_IF);
          d_ack  <= (grant == GNT_D);
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized
// request traffic compared against a slot-level arbitration/memory model.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Known initial RAM contents shared by the RAM environment and the model.
  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 16) return 16'hBEEF;
    return 16'((a * 257) ^ 16'h5A5A);
  endfunction

  // Single-port RAM environment with one-cycle read latency.
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model state: pending requests, expected memory, last grant.
  logic [DW-1:0] ref_mem [0:255];
  bit            p_if, p_d, we_d;
  logic [AW-1:0] a_if, a_d;
  logic [DW-1:0] wd_d;
  int            last_w;     // 0 = fetch, 1 = data
  int            hist[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Winner of the next slot from the arbitration rules.
  function automatic int pick();
    if (p_if && p_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (last_w == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    return p_d ? 1 : 0;
  endfunction

  // One arbitration slot starting at a negedge with the DUT idle.
  task automatic run_slot(input bit keep, input bit noise);
    int w;
    logic [AW-1:0] ea;
    if_req  = p_if;  if_addr = a_if;
    d_req   = p_d;   d_addr  = a_d;  d_we = we_d;  d_wdata = wd_d;
    if (!p_if && !p_d) begin
      @(posedge clk); #1;
      check("idle_busy", 32'(busy), 0);
      check("idle_en", 32'(mem_en), 0);
      check("idle_acks", 32'({if_ack, d_ack}), 0);
      @(negedge clk);
      return;
    end
    w = pick();
    last_w = w;
    hist.push_back(w);
    ea = (w == 1) ? a_d : a_if;
    @(posedge clk); #1;
    check("issue_busy", 32'(busy), 1);
    check("issue_en", 32'(mem_en), 1);
    check("issue_we", 32'(mem_we), 32'((w == 1) && we_d));
    check("issue_addr", 32'(mem_addr), 32'(ea));
    if (w == 1 && we_d) check("issue_wdata", 32'(mem_wdata), 32'(wd_d));
    check("issue_acks", 32'({if_ack, d_ack}), 0);
    if (noise) begin
      if (!p_if) begin if_req = 1'b1; if_addr = AW'($urandom); end
      if (!p_d)  begin d_req = 1'b1; d_we = 1'($urandom); d_addr = AW'($urandom); end
    end
    @(posedge clk); #1;
    check("done_if_ack", 32'(if_ack), 32'(w == 0));
    check("done_d_ack", 32'(d_ack), 32'(w == 1));
    check("done_en", 32'(mem_en), 0);
    check("done_busy", 32'(busy), 1);
    if (w == 0) check("if_rdata", 32'(if_rdata), 32'(ref_mem[a_if]));
    else if (!we_d) check("d_rdata", 32'(d_rdata), 32'(ref_mem[a_d]));
    if (w == 1 && we_d) ref_mem[a_d] = wd_d;
    if (!keep) begin
      if (w == 0) begin p_if = 0; if_req = 1'b0; end
      else begin p_d = 0; d_req = 1'b0; end
    end
    if (noise) begin
      if (!p_if) if_req = 1'($urandom);
      if (!p_d)  d_req  = 1'($urandom);
    end
    @(posedge clk); #1;
    check("idle_after_busy", 32'(busy), 0);
    check("idle_after_acks", 32'({if_ack, d_ack}), 0);
    check("idle_after_en", 32'(mem_en), 0);
    check("addr_hold", 32'(mem_addr), 32'(ea));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    p_if = 0; p_d = 0; we_d = 0; a_if = '0; a_d = '0; wd_d = '0;
    last_w = 1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'({busy, mem_en, mem_we, if_ack, d_ack}), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    @(negedge clk);
    rst = 1'b0;

    // Contention with both requests held continuously.
    p_if = 1; a_if = 8'h10; p_d = 1; a_d = 8'h11; we_d = 0;
    hist.delete();
    for (int i = 0; i < 4; i++) run_slot(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      int exp_w;
`ifdef ARB_ROUND_ROBIN_EN
      exp_w = i % 2;
`else
      exp_w = 1;
`endif
      check("contend_order", 32'(hist[i]), 32'(exp_w));
    end
    p_if = 0; p_d = 0;

    // Single fetch from 0x10.
    p_if = 1; a_if = 8'h10;
    run_slot(1'b0, 1'b0);

    // Store 0x1234 to 0x20, then load it back.
    p_d = 1; a_d = 8'h20; we_d = 1; wd_d = 16'h1234;
    run_slot(1'b0, 1'b0);
    p_d = 1; a_d = 8'h20; we_d = 0;
    run_slot(1'b0, 1'b0);

    // Fetch request noise during a data access, then an idle slot.
    p_d = 1; a_d = 8'h30; we_d = 0;
    run_slot(1'b0, 1'b1);
    run_slot(1'b0, 1'b0);

    // Reset pulse while an access is in ISSUE.
    p_if = 1; a_if = 8'h05;
    if_req = 1'b1; if_addr = a_if;
    @(posedge clk); #1;
    check("rst_pre_en", 32'(mem_en), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ctrl", 32'({busy, mem_en, mem_we, if_ack, d_ack}), 0);
    check("rst_mid_addr", 32'(mem_addr), 0);
    check("rst_mid_wdata", 32'(mem_wdata), 0);
    if_req = 1'b0; p_if = 0; last_w = 1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_no_ack", 32'({if_ack, d_ack}), 0);
    end
    @(negedge clk);
    p_if = 1; a_if = 8'h10;
    run_slot(1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      if (!p_if && ($urandom % 2 == 1)) begin
        p_if = 1; a_if = 8'($urandom_range(0, 31));
      end
      if (!p_d && ($urandom % 2 == 1)) begin
        p_d = 1; a_d = 8'($urandom_range(0, 31));
        we_d = 1'($urandom); wd_d = 16'($urandom);
      end
      run_slot($urandom % 4 == 0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
